// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op and FSM encodings, and small op-decode helpers for the MEM stage.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int MemOpBus   = 4;

    typedef enum logic [MemOpBus-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

    // Number of byte transfers an op needs.
    function automatic logic [2:0] op_len(input mem_op_e op);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
            OP_LW, OP_SW:         op_len = 3'd4;
            default:              op_len = 3'd1;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_e op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = a[0];
            OP_LW, OP_SW:         is_misaligned = (a != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, byte-RAM port and writeback/stall outputs of the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [RegAddrBus-1:0] ex_w_addr;
    logic                  ex_w_req;
    logic [RegBus-1:0]     ex_w_data;
    logic [MemOpBus-1:0]   ex_mem_op;
    logic [RegBus-1:0]     ex_mem_addr;
    logic [RegBus-1:0]     ex_store_data;
    logic                  ram_gnt;
    logic [7:0]            ram_din;
    logic [RegBus-1:0]     ram_a;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic [RegAddrBus-1:0] mem_w_addr;
    logic                  mem_w_req;
    logic [RegBus-1:0]     mem_w_data;
    logic                  stall_req;
    logic                  misalign;

    modport master (
        input  ex_w_addr, ex_w_req, ex_w_data, ex_mem_op, ex_mem_addr, ex_store_data,
        input  ram_gnt, ram_din,
        output ram_a, ram_wr, ram_dout,
        output mem_w_addr, mem_w_req, mem_w_data, stall_req, misalign
    );

    modport slave (
        output ex_w_addr, ex_w_req, ex_w_data, ex_mem_op, ex_mem_addr, ex_store_data,
        output ram_gnt, ram_din,
        input  ram_a, ram_wr, ram_dout,
        input  mem_w_addr, mem_w_req, mem_w_data, stall_req, misalign
    );

endinterface

// File: rtl/mem_load_ext.sv
// Assembles captured bytes (LSB first) into a load result with sign/zero extension.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  mem_op_e           op,
    input  logic [3:0][7:0]   bytes,
    output logic [RegBus-1:0] data
);

    always_comb begin
        data = '0;
        case (op)
            OP_LB:   data = {{24{bytes[0][7]}}, bytes[0]};
            OP_LBU:  data = {24'd0, bytes[0]};
            OP_LH:   data = {{16{bytes[1][7]}}, bytes[1], bytes[0]};
            OP_LHU:  data = {16'd0, bytes[1], bytes[0]};
            OP_LW:   data = {bytes[3], bytes[2], bytes[1], bytes[0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial load/store over an arbitrated 8-bit RAM port.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a misalign pulse.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    mem_stage_if.master bus
);

    mem_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    mem_op_e           op_q, op_d;
    logic [RegBus-1:0] addr_q, addr_d;
    logic [3:0][7:0]   sdata_q, sdata_d;
    logic [3:0][7:0]   bytes_q, bytes_d;
    logic              rd_pend_q, rd_pend_d;
    logic [RegBus-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    mem_op_e           in_op;
    logic              misal;
    logic [1:0]        cap_idx;
    logic [RegBus-1:0] ext_data;

    assign in_op = mem_op_e'(bus.ex_mem_op);

`ifdef MEM_ALIGN_CHECK_EN
    assign misal         = is_misaligned(in_op, bus.ex_mem_addr[1:0]);
    assign bus.misalign  = rst && (state_q == ST_IDLE) && misal;
`else
    assign misal         = 1'b0;
    assign bus.misalign  = 1'b0;
`endif

    // The byte returning now belongs to the issue before the last cnt increment.
    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        bytes_d    = bytes_q;
        rd_pend_d  = 1'b0;
        ram_a_d    = '0;
        ram_wr_d   = 1'b0;
        ram_dout_d = '0;

        if (rd_pend_q) bytes_d[cap_idx] = bus.ram_din;

        case (state_q)
            ST_IDLE: begin
                if (in_op != OP_NONE && !misal) begin
                    op_d    = in_op;
                    addr_d  = bus.ex_mem_addr;
                    sdata_d = bus.ex_store_data;
                    bytes_d = '0;
                    cnt_d   = 3'd0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.ram_gnt) begin
                    ram_a_d = addr_q + 32'(cnt_q);
                    if (is_store(op_q)) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = sdata_q[cnt_q[1:0]];
                    end else begin
                        rd_pend_d  = 1'b1;
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == op_len(op_q))
                        state_d = is_store(op_q) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            sdata_q    <= '0;
            bytes_q    <= '0;
            rd_pend_q  <= 1'b0;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            bytes_q    <= bytes_d;
            rd_pend_q  <= rd_pend_d;
            ram_a_q    <= ram_a_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    mem_load_ext u_ext (
        .op    (op_q),
        .bytes (bytes_q),
        .data  (ext_data)
    );

    assign bus.ram_a    = ram_a_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_dout = ram_dout_q;

    // Writeback/stall are combinational so an ALU result passes straight through in IDLE.
    always_comb begin
        bus.mem_w_addr = bus.ex_w_addr;
        bus.mem_w_req  = 1'b0;
        bus.mem_w_data = '0;
        bus.stall_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_op == OP_NONE) begin
                    bus.mem_w_req  = bus.ex_w_req;
                    bus.mem_w_data = bus.ex_w_data;
                end else if (!misal) begin
                    bus.stall_req  = 1'b1;
                end
            end
            ST_ACCESS, ST_WAIT: bus.stall_req = 1'b1;
            default: begin
                if (!is_store(op_q)) begin
                    bus.mem_w_req  = bus.ex_w_req;
                    bus.mem_w_data = ext_data;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores against a byte RAM model, grant/rdy gaps, reset abort, wrap.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_stage_if bus();

    mem_stage dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    logic [39:0] wr_log [$];
    logic [31:0] ra_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    assign bus.ram_din = mem[bus.ram_a[9:0]];

    always @(posedge clk)
        if (rst && bus.ram_wr) wr_log.push_back({bus.ram_a, bus.ram_dout});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
        bus.ex_mem_op = OP_NONE;
        bus.ram_gnt   = 1'b1;
        rdy           = 1'b1;
    endtask

    // Starts at edge+1 of an IDLE cycle; returns in the first cycle with stall_req low.
    task automatic run_op(input mem_op_e op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [15:0] gmask, input logic [15:0] rmask,
                          output int stalls, output logic [31:0] wd,
                          output logic wr, output logic mis);
        bit done = 0;
        stalls = 0; wd = '0; wr = 1'b0; mis = 1'b0;
        ra_q.delete();
        bus.ex_mem_op     = op;
        bus.ex_mem_addr   = a;
        bus.ex_store_data = sd;
        bus.ex_w_req      = 1'b1;
        bus.ex_w_addr     = 5'd9;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.ram_gnt = (k < 16) ? ~gmask[k] : 1'b1;
            rdy         = (k < 16) ? ~rmask[k] : 1'b1;
            #1;
            if (!bus.stall_req) begin
                wd = bus.mem_w_data; wr = bus.mem_w_req; mis = bus.misalign;
                done = 1;
            end else begin
                stalls++;
                if (k >= 2) ra_q.push_back(bus.ram_a);
                @(posedge clk); #1;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          st;
        logic [31:0] wd;
        logic        wr, mis;
        int          base;
        logic [31:0] swd;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
        mem[10'h003] = 8'h80;
        mem[10'h010] = 8'h34; mem[10'h011] = 8'h92;
        mem[10'h3FE] = 8'hA1; mem[10'h3FF] = 8'hB2; mem[10'h000] = 8'hC3; mem[10'h001] = 8'hD4;

        rst = 1'b0; rdy = 1'b1;
        bus.ram_gnt = 1'b1;
        bus.ex_mem_op = OP_NONE; bus.ex_mem_addr = '0; bus.ex_store_data = '0;
        bus.ex_w_addr = 5'h1F; bus.ex_w_req = 1'b1; bus.ex_w_data = 32'h1234_5678;

        #12;
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_wr", bus.ram_wr, 1'b0);
        chk("rst_ram_dout", bus.ram_dout, 8'h0);
        chk("rst_misalign", bus.misalign, 1'b0);
        chk("rst_stall", bus.stall_req, 1'b0);
        chk("rst_pass_data", bus.mem_w_data, 32'h1234_5678);
        chk("rst_pass_req", bus.mem_w_req, 1'b1);
        chk("rst_pass_addr", bus.mem_w_addr, 5'h1F);

        @(posedge clk); #1; rst = 1'b1;
        nxt();

        run_op(OP_LW, 32'h100, '0, '0, '0, st, wd, wr, mis);
        chk("lw_stalls", st, 6);
        chk("lw_data", wd, 32'h1234_5678);
        chk("lw_req", wr, 1'b1);
        chk("lw_addr_n", ra_q.size(), 4);
        for (int i = 0; i < 4 && i < ra_q.size(); i++) chk("lw_addr", ra_q[i], 32'h100 + i);

        nxt();
        bus.ex_w_data = 32'hCAFE_BABE; bus.ex_w_addr = 5'd7; bus.ex_w_req = 1'b1;
        #1;
        chk("alu_stall", bus.stall_req, 1'b0);
        chk("alu_data", bus.mem_w_data, 32'hCAFE_BABE);
        chk("alu_req", bus.mem_w_req, 1'b1);
        chk("alu_addr", bus.mem_w_addr, 5'd7);

        nxt();
        run_op(OP_LB, 32'h3, '0, '0, '0, st, wd, wr, mis);
        chk("lb_stalls", st, 3);
        chk("lb_data", wd, 32'hFFFF_FF80);
        nxt();
        run_op(OP_LBU, 32'h3, '0, '0, '0, st, wd, wr, mis);
        chk("lbu_data", wd, 32'h0000_0080);
        nxt();
        run_op(OP_LH, 32'h10, '0, '0, '0, st, wd, wr, mis);
        chk("lh_data", wd, 32'hFFFF_9234);
        nxt();
        run_op(OP_LHU, 32'h10, '0, '0, '0, st, wd, wr, mis);
        chk("lhu_data", wd, 32'h0000_9234);

        nxt();
        run_op(OP_LW, 32'h100, '0, '0, 16'h000C, st, wd, wr, mis);
        chk("rdy_stalls", st, 8);
        chk("rdy_data", wd, 32'h1234_5678);

        nxt();
        base = wr_log.size();
        swd  = 32'hAABB_CCDD;
        run_op(OP_SW, 32'h200, swd, 16'h000C, '0, st, wd, wr, mis);
        chk("sw_stalls", st, 7);
        chk("sw_req", wr, 1'b0);
        nxt();
        nxt();
        chk("sw_wr_cnt", wr_log.size() - base, 4);
        for (int i = 0; i < 4 && base + i < wr_log.size(); i++) begin
            chk("sw_wr_addr", wr_log[base + i][39:8], 32'h200 + i);
            chk("sw_wr_data", wr_log[base + i][7:0], swd[i*8 +: 8]);
        end
        chk("sw_idle_wr", bus.ram_wr, 1'b0);

        // Reset while the third store byte is on the RAM port.
        base = wr_log.size();
        nxt();
        bus.ex_mem_op = OP_SW; bus.ex_mem_addr = 32'h300; bus.ex_store_data = 32'h1122_3344;
        repeat (4) @(posedge clk);
        #2;
        chk("rsw_wr_pre", bus.ram_wr, 1'b1);
        chk("rsw_a_pre", bus.ram_a, 32'h302);
        chk("rsw_dout_pre", bus.ram_dout, 8'h22);
        rst = 1'b0; bus.ex_mem_op = OP_NONE;
        #1;
        chk("rsw_wr_rst", bus.ram_wr, 1'b0);
        chk("rsw_a_rst", bus.ram_a, 32'h0);
        chk("rsw_stall_rst", bus.stall_req, 1'b0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rsw_wr_cnt", wr_log.size() - base, 2);
        chk("rsw_wr_after", bus.ram_wr, 1'b0);

        nxt();
        run_op(OP_LW, 32'hFFFF_FFFE, '0, '0, '0, st, wd, wr, mis);
`ifdef MEM_ALIGN_CHECK_EN
        chk("wrap_stalls", st, 0);
        chk("wrap_misalign", mis, 1'b1);
        chk("wrap_req", wr, 1'b0);
        chk("wrap_no_access", bus.ram_a, 32'h0);
`else
        chk("wrap_stalls", st, 6);
        chk("wrap_misalign", mis, 1'b0);
        chk("wrap_data", wd, 32'hD4C3_B2A1);
        chk("wrap_addr_n", ra_q.size(), 4);
        if (ra_q.size() == 4) begin
            chk("wrap_a0", ra_q[0], 32'hFFFF_FFFE);
            chk("wrap_a1", ra_q[1], 32'hFFFF_FFFF);
            chk("wrap_a2", ra_q[2], 32'h0000_0000);
            chk("wrap_a3", ra_q[3], 32'h0000_0001);
        end
`endif
        nxt();
        #1;
        chk("end_misalign", bus.misalign, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
